// File: rtl/stack_seq.sv
// Stack access sequencer: runs 1..3 byte pushes or pulls on the stack page and
// strobes the regfile S pointer once per completed bus access.
module stack_seq #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic        op,
  input  logic [1:0]  cnt,
  input  logic [23:0] din,
  input  logic [7:0]  S,
  input  logic        RDY,
  input  logic [7:0]  DI,
  output logic [15:0] AB,
  output logic [7:0]  DO,
  output logic        WE,
  output logic        push,
  output logic        pull,
  output logic        busy,
  output logic        done,
  output logic [23:0] dout
);

  typedef enum logic [1:0] {IDLE, PUSH, PULL, PCAP} state_t;

  state_t      state_reg;
  logic [1:0]  cnt_reg;
  logic [1:0]  rem_reg;
  logic [1:0]  k_reg;
  logic [23:0] din_reg;
  logic [23:0] dout_reg;
  logic        done_reg;

  logic [1:0]  byte_sel;
  logic [4:0]  push_bit;
  logic [4:0]  cap_bit;

  // Bus outputs follow the live S so each access sees the previous strobe.
  always_comb begin
    byte_sel = cnt_reg - 2'd1 - k_reg;
    push_bit = {byte_sel, 3'b000};
    cap_bit  = {k_reg - 2'd1, 3'b000};
    AB   = 16'h0000;
    DO   = 8'h00;
    WE   = 1'b0;
    push = 1'b0;
    pull = 1'b0;
    case (state_reg)
      PUSH: begin
        AB   = {STACK_PAGE, S};
        DO   = din_reg[push_bit +: 8];
        WE   = RDY;
        push = RDY;
      end
      PULL: begin
        AB   = {STACK_PAGE, S + 8'd1};
        pull = RDY;
      end
      default: ;
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign dout = dout_reg;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      rem_reg   <= 2'd0;
      k_reg     <= 2'd0;
      din_reg   <= 24'h0;
      dout_reg  <= 24'h0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && cnt != 2'd0) begin
            cnt_reg   <= cnt;
            rem_reg   <= cnt;
            k_reg     <= 2'd0;
            din_reg   <= din;
            dout_reg  <= 24'h0;
            state_reg <= op ? PULL : PUSH;
          end
        end
        PUSH: begin
          if (RDY) begin
            k_reg   <= k_reg + 2'd1;
            rem_reg <= rem_reg - 2'd1;
            if (rem_reg == 2'd1) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        PULL: begin
          if (RDY) begin
            // DI now carries the byte addressed on the previous access
            if (k_reg != 2'd0)
              dout_reg[cap_bit +: 8] <= DI;
            k_reg   <= k_reg + 2'd1;
            rem_reg <= rem_reg - 2'd1;
            if (rem_reg == 2'd1)
              state_reg <= PCAP;
          end
        end
        PCAP: begin
          if (RDY) begin
            dout_reg[cap_bit +: 8] <= DI;
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: memory + S-pointer environment, LIFO reference model,
// directed scenarios and randomized push/pull traffic with RDY stalls.
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        RST, start, op;
  logic [1:0]  cnt;
  logic [23:0] din;
  logic [7:0]  S;
  logic        RDY;
  logic [7:0]  DI;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE, push, pull, busy, done;
  logic [23:0] dout;

  always #5 clk = ~clk;

  stack_seq dut (
    .clk(clk), .RST(RST), .start(start), .op(op), .cnt(cnt), .din(din),
    .S(S), .RDY(RDY), .DI(DI), .AB(AB), .DO(DO), .WE(WE), .push(push),
    .pull(pull), .busy(busy), .done(done), .dout(dout)
  );

  int tests_run = 0;
  int fails = 0;

  // environment: page-1 memory, regfile S pointer, bus logs
  logic [7:0]  mem [256];
  logic [15:0] wlog_addr[$];
  logic [7:0]  wlog_data[$];
  logic [15:0] rlog[$];
  int push_total = 0, done_total = 0, both_total = 0, page_bad = 0;
  logic        s_load = 1'b0;
  logic [7:0]  s_load_val = 8'h00;
  int          stall_pct = 0;
  logic        force_stall = 1'b0;

  always @(posedge clk) begin
    if (WE) begin
      wlog_addr.push_back(AB);
      wlog_data.push_back(DO);
      mem[AB[7:0]] <= DO;
    end
    if (pull) rlog.push_back(AB);
    if (push) push_total++;
    if (done) done_total++;
    if (push && pull) both_total++;
    if ((WE || push || pull) && AB[15:8] != 8'h01) page_bad++;
    if (RDY) DI <= mem[AB[7:0]];
    if (s_load) S <= s_load_val;
    else if (push) S <= S - 8'd1;
    else if (pull) S <= S + 8'd1;
  end

  always @(negedge clk)
    RDY = !(force_stall || (int'($urandom_range(99)) < stall_pct));

  // reference model: a LIFO of bytes plus the expected pointer
  logic [7:0]  ref_stack[$];
  logic [7:0]  ref_s;
  logic [15:0] exp_waddr[$];
  logic [7:0]  exp_wdata[$];
  logic [15:0] exp_raddr[$];
  logic [23:0] exp_dout;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_seq(input logic o, input int n, input logic [23:0] d);
    logic [7:0] b;
    exp_waddr.delete(); exp_wdata.delete(); exp_raddr.delete();
    exp_dout = 24'h0;
    for (int k = 0; k < n; k++) begin
      if (!o) begin
        b = d[8*(n-1-k) +: 8];
        exp_waddr.push_back({8'h01, ref_s});
        exp_wdata.push_back(b);
        ref_stack.push_back(b);
        ref_s = ref_s - 8'd1;
      end else begin
        ref_s = ref_s + 8'd1;
        exp_raddr.push_back({8'h01, ref_s});
        exp_dout[8*k +: 8] = ref_stack.pop_back();
      end
    end
  endtask

  task automatic load_s(input logic [7:0] v);
    s_load = 1'b1; s_load_val = v;
    tick();
    s_load = 1'b0;
    ref_s = v;
    ref_stack.delete();
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (done === 1'b1) got = 1;
    end
    tests_run++;
    if (!got) begin
      fails++;
      $display("FAIL %s timeout: done=%b required 1 within 300 cycles", name, done);
    end
  endtask

  task automatic check_results(input int wb, input int rb, input int pb, input string name);
    int nw = wlog_addr.size() - wb;
    int nr = rlog.size() - rb;
    tests_run++;
    if (nw != exp_waddr.size()) begin
      fails++; $display("FAIL %s write_count: got %0d required %0d", name, nw, exp_waddr.size());
    end else
      for (int k = 0; k < nw; k++) begin
        tests_run++;
        if ({wlog_addr[wb+k], wlog_data[wb+k]} !== {exp_waddr[k], exp_wdata[k]}) begin
          fails++;
          $display("FAIL %s write%0d: got %h<=%h required %h<=%h", name, k,
                   wlog_addr[wb+k], wlog_data[wb+k], exp_waddr[k], exp_wdata[k]);
        end
      end
    tests_run++;
    if (nr != exp_raddr.size()) begin
      fails++; $display("FAIL %s read_count: got %0d required %0d", name, nr, exp_raddr.size());
    end else
      for (int k = 0; k < nr; k++) begin
        tests_run++;
        if (rlog[rb+k] !== exp_raddr[k]) begin
          fails++; $display("FAIL %s read%0d: got %h required %h", name, k, rlog[rb+k], exp_raddr[k]);
        end
      end
    tests_run++;
    if (push_total - pb != exp_waddr.size()) begin
      fails++; $display("FAIL %s push_strobes: got %0d required %0d", name, push_total - pb, exp_waddr.size());
    end
    tests_run++;
    if (dout !== exp_dout) begin
      fails++; $display("FAIL %s dout: got %h required %h", name, dout, exp_dout);
    end
    tests_run++;
    if (S !== ref_s) begin
      fails++; $display("FAIL %s S: got %h required %h", name, S, ref_s);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL %s busy_at_done: got %b required 0", name, busy);
    end
    $display("[TB] %s op=%0d cnt=%0d din=%h dout=%h S=%h writes=%0d reads=%0d",
             name, op, cnt, din, dout, S, nw, nr);
  endtask

  // Starts immediately, so a call made right at a done pulse exercises start+done.
  task automatic run_seq(input logic o, input logic [1:0] c, input logic [23:0] d,
                         input int interfere_at, input string name);
    int wb, rb, pb;
    model_seq(o, int'(c), d);
    start = 1'b1; op = o; cnt = c; din = d;
    tick();
    start = 1'b0;
    wb = wlog_addr.size(); rb = rlog.size(); pb = push_total;
    if (interfere_at >= 0) begin
      repeat (interfere_at) tick();
      start = 1'b1; op = ~o; cnt = 2'd1; din = $urandom;
      tick();
      start = 1'b0; op = o; cnt = c; din = d;
    end
    wait_done(name);
    check_results(wb, rb, pb, name);
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; op = 1'b0; cnt = 2'd0; din = 24'h0;
    s_load = 1'b1; s_load_val = 8'hFF;
    repeat (3) tick();
    s_load = 1'b0;
    tests_run++;
    if ({AB, DO} !== 24'h0) begin
      fails++; $display("FAIL reset_bus: got AB=%h DO=%h required 0000/00", AB, DO);
    end
    tests_run++;
    if ({WE, push, pull, busy, done} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 00000", {WE, push, pull, busy, done});
    end
    tests_run++;
    if (dout !== 24'h0) begin
      fails++; $display("FAIL reset_dout: got %h required 000000", dout);
    end
    RST = 1'b0;
    ref_s = 8'hFF;
    ref_stack.delete();
    tick();
    $display("[TB] reset AB=%h WE=%b busy=%b done=%b dout=%h", AB, WE, busy, done, dout);
  endtask

  task automatic test_push_pull();
    run_seq(1'b0, 2'd3, 24'h123456, -1, "push3");
    tests_run++;
    if (S !== 8'hFC) begin
      fails++; $display("FAIL push3_S: got %h required FC", S);
    end
    run_seq(1'b1, 2'd3, 24'h0, -1, "pull3");
    tests_run++;
    if (dout !== 24'h123456 || S !== 8'hFF) begin
      fails++; $display("FAIL pull3_result: got dout=%h S=%h required 123456/FF", dout, S);
    end
  endtask

  task automatic test_stall();
    int wb, rb, pb, db;
    logic [15:0] a0;
    logic [7:0]  d0;
    tick();
    model_seq(1'b0, 2, 24'h00BEEF);
    start = 1'b1; op = 1'b0; cnt = 2'd2; din = 24'h00BEEF;
    tick();
    start = 1'b0;
    wb = wlog_addr.size(); rb = rlog.size(); pb = push_total; db = done_total;
    @(posedge clk); #1;
    force_stall = 1'b1;
    tick();
    a0 = AB; d0 = DO;
    tests_run++;
    if ({a0, d0} !== {exp_waddr[1], exp_wdata[1]}) begin
      fails++; $display("FAIL stall_bus: got %h/%h required %h/%h", a0, d0, exp_waddr[1], exp_wdata[1]);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick();
      tests_run++;
      if (WE !== 1'b0 || push !== 1'b0 || AB !== a0 || DO !== d0) begin
        fails++; $display("FAIL stall_hold%0d: got WE=%b push=%b AB=%h DO=%h required 0/0/%h/%h",
                          i, WE, push, AB, DO, a0, d0);
      end
    end
    force_stall = 1'b0;
    wait_done("stall");
    check_results(wb, rb, pb, "stall");
    tick();
    tests_run++;
    if (done_total - db != 1 || done !== 1'b0) begin
      fails++; $display("FAIL stall_done_once: got %0d pulses done=%b required 1/0", done_total - db, done);
    end
  endtask

  task automatic test_wrap();
    tick();
    load_s(8'h00);
    run_seq(1'b0, 2'd1, 24'h0000AA, -1, "wrap_push");
    tests_run++;
    if (wlog_addr[$] !== 16'h0100 || S !== 8'hFF) begin
      fails++; $display("FAIL wrap_push: got addr=%h S=%h required 0100/FF", wlog_addr[$], S);
    end
    run_seq(1'b1, 2'd1, 24'hFFFFFF, -1, "wrap_pull");
    tests_run++;
    if (rlog[$] !== 16'h0100 || dout !== 24'h0000AA) begin
      fails++; $display("FAIL wrap_pull: got addr=%h dout=%h required 0100/0000AA", rlog[$], dout);
    end
  endtask

  task automatic test_noop_and_busy();
    int wb, rb, db;
    tick();
    wb = wlog_addr.size(); rb = rlog.size(); db = done_total;
    start = 1'b1; op = 1'b0; cnt = 2'd0; din = 24'h777777;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL noop%0d: got busy=%b done=%b required 0/0", i, busy, done);
      end
      tick();
    end
    tests_run++;
    if (wlog_addr.size() != wb || rlog.size() != rb || done_total != db) begin
      fails++; $display("FAIL noop_bus: got %0d writes %0d reads %0d dones required 0",
                        wlog_addr.size() - wb, rlog.size() - rb, done_total - db);
    end
    $display("[TB] noop cnt=0 busy=%b done=%b", busy, done);
    run_seq(1'b0, 2'd3, 24'hA1B2C3, 0, "busy_ignore");
  endtask

  task automatic test_reset_mid();
    int wb;
    tick();
    load_s(8'hFF);
    start = 1'b1; op = 1'b0; cnt = 2'd3; din = 24'hC0FFEE;
    tick();
    start = 1'b0;
    wb = wlog_addr.size();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tests_run++;
    if ({WE, push, pull, busy, done} !== 5'b0 || AB !== 16'h0 || dout !== 24'h0) begin
      fails++; $display("FAIL reset_mid_outputs: got ctrl=%b AB=%h dout=%h required 0",
                        {WE, push, pull, busy, done}, AB, dout);
    end
    tests_run++;
    if (wlog_addr.size() - wb != 2) begin
      fails++; $display("FAIL reset_mid_writes: got %0d required 2", wlog_addr.size() - wb);
    end else begin
      tests_run++;
      if ({wlog_addr[wb], wlog_data[wb], wlog_addr[wb+1], wlog_data[wb+1]} !== 48'h01FFC0_01FEFF) begin
        fails++; $display("FAIL reset_mid_data: got %h<=%h %h<=%h required 01FF<=C0 01FE<=FF",
                          wlog_addr[wb], wlog_data[wb], wlog_addr[wb+1], wlog_data[wb+1]);
      end
    end
    tests_run++;
    if (S !== 8'hFD) begin
      fails++; $display("FAIL reset_mid_S: got %h required FD", S);
    end
    $display("[TB] reset_mid writes=%0d S=%h busy=%b", wlog_addr.size() - wb, S, busy);
    ref_s = 8'hFD;
    ref_stack.push_back(8'hC0);
    ref_stack.push_back(8'hFF);
    tick();
  endtask

  task automatic test_random();
    logic       o;
    logic [1:0] c;
    stall_pct = 30;
    for (int i = 0; i < 24; i++) begin
      c = 2'($urandom_range(3, 1));
      o = (ref_stack.size() >= int'(c)) ? 1'($urandom_range(1)) : 1'b0;
      run_seq(o, c, $urandom, -1, "random");
    end
    stall_pct = 0;
  endtask

  task automatic test_strobes();
    tests_run++;
    if (both_total != 0) begin
      fails++; $display("FAIL strobe_exclusive: got %0d overlaps required 0", both_total);
    end
    tests_run++;
    if (page_bad != 0) begin
      fails++; $display("FAIL stack_page: got %0d off-page accesses required 0", page_bad);
    end
  endtask

  initial begin
    test_reset();
    test_push_pull();
    test_stall();
    test_wrap();
    test_noop_and_busy();
    test_reset_mid();
    test_random();
    test_strobes();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
